slice_adder: RTL and testbench

SLICE_ADDER -- requirements
Module: slice_adder

---
 rtl/slice_adder.sv | 134 +++++++++++++
 tb/tb_slice_adder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_adder.sv
// Multi-cycle adder/subtractor: SLICE_WIDTH bits per cycle, LSB slice first,
// with PIC-style carry (1 = no borrow), digit carry, zero and signed overflow flags.
module slice_adder #(
  parameter int DATA_WIDTH  = 8,
  parameter int SLICE_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Both handshakes: a transfer happens at a rising edge where valid and ready
  // are both 1; valid may rise on its own, and the payload is held until taken.
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            mode,
  input  logic                  carryIn,
  input  logic                  abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  digitCarry,
  output logic                  zero,
  output logic                  overflow,
  output logic [1:0]            state_dbg
);

  localparam int N  = DATA_WIDTH / SLICE_WIDTH;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   a_r;
  logic [DATA_WIDTH-1:0]   b_r;
  logic [DATA_WIDTH-1:0]   acc;
  logic                    run_c;
  logic                    dc_r;
  logic [IW-1:0]           idx;

  logic [SLICE_WIDTH-1:0]  a_sl;
  logic [SLICE_WIDTH-1:0]  b_sl;
  logic [SLICE_WIDTH:0]    slice_sum;
  logic                    c_out;
  logic                    c_msb_in;
  logic                    last;
  logic [DATA_WIDTH-1:0]   next_acc;

  assign state_dbg = state;

  always_comb begin
    a_sl      = a_r[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH];
    b_sl      = b_r[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH];
    slice_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_WIDTH{1'b0}}, run_c};
    c_out     = slice_sum[SLICE_WIDTH];
    // Carry into the slice MSB recovered from its sum bit and operand bits.
    c_msb_in  = slice_sum[SLICE_WIDTH-1] ^ a_sl[SLICE_WIDTH-1] ^ b_sl[SLICE_WIDTH-1];
    last      = (idx == IW'(N-1));
    next_acc  = acc;
    next_acc[int'(idx)*SLICE_WIDTH +: SLICE_WIDTH] = slice_sum[SLICE_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      a_r        <= '0;
      b_r        <= '0;
      acc        <= '0;
      run_c      <= 1'b0;
      dc_r       <= 1'b0;
      idx        <= '0;
      result     <= '0;
      carry      <= 1'b0;
      digitCarry <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= mode[0] ? ~b : b;
            run_c    <= mode[1] ? carryIn : mode[0];
            idx      <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
          end
        end
        CALC: begin
          if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end else begin
            acc   <= next_acc;
            run_c <= c_out;
            if (idx == '0) dc_r <= c_out;
            if (last) begin
              result     <= next_acc;
              carry      <= c_out;
              digitCarry <= (idx == '0) ? c_out : dc_r;
              zero       <= (next_acc == '0);
              overflow   <= c_msb_in ^ c_out;
              state      <= DONE;
              out_valid  <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        DONE: begin
          // abort and out_ready both release the result; abort just discards it.
          if (abort || out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_adder.sv
// Directed bench for slice_adder (8-bit, 4-bit slices): driver pushes expected
// results, a negedge monitor pops and compares every accepted output.
module tb_slice_adder;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int N  = DW / SW;
  localparam int EW = DW + 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [1:0]    mode;
  logic          carryIn;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          carry;
  logic          digitCarry;
  logic          zero;
  logic          overflow;
  logic [1:0]    state_dbg;

  // expected word: {result, carry, digitCarry, zero, overflow}
  logic [EW-1:0] exp_q[$];
  int            lat_q[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;

  typedef struct {
    logic [DW-1:0] va;
    logic [DW-1:0] vb;
    logic [1:0]    vm;
    logic          vc;
    logic [EW-1:0] ve;
  } vec_t;
  vec_t vecs[10];

  slice_adder #(.DATA_WIDTH(DW), .SLICE_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .carryIn(carryIn), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .digitCarry(digitCarry),
    .zero(zero), .overflow(overflow), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // monitor / scoreboard
  logic          prev_valid = 1'b0;
  logic [EW-1:0] e;
  int            lat_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) check("unexpected out_valid", 32'(out_valid), 32'd0);
        else begin
          lat_exp = lat_q.pop_front();
          check("latency", 32'(cyc), 32'(lat_exp));
        end
      end
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) check("unexpected result", 32'(out_valid), 32'd0);
        else begin
          e = exp_q.pop_front();
          check("result", 32'(result), 32'(e[EW-1:4]));
          check("carry", 32'(carry), 32'(e[3]));
          check("digitCarry", 32'(digitCarry), 32'(e[2]));
          check("zero", 32'(zero), 32'(e[1]));
          check("overflow", 32'(overflow), 32'(e[0]));
        end
      end
    end
    prev_valid = out_valid;
  end

  // driver tasks
  task automatic issue(input logic [DW-1:0] ia, input logic [DW-1:0] ib, input logic [1:0] im,
                       input logic ic, input logic [EW-1:0] iexp, input bit expect_res,
                       output int acc_cyc);
    logic rdy;
    a = ia; b = ib; mode = im; carryIn = ic; in_valid = 1'b1;
    if (expect_res) exp_q.push_back(iexp);
    acc_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        #1;
        acc_cyc = cyc;
        break;
      end
    end
    if (acc_cyc < 0) timeout_fail("accept");
    else if (expect_res) lat_q.push_back(acc_cyc + N);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("wait_idle");
    @(posedge clk);
    #1;
  endtask

  int c1, c2, rel_cyc;
  bit seen;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 2'b00, 1'b0, 12'h104};
    vecs[1] = '{8'h05, 8'h05, 2'b01, 1'b0, 12'h00E};
    vecs[2] = '{8'h00, 8'h01, 2'b01, 1'b0, 12'hFF0};
    vecs[3] = '{8'h7F, 8'h01, 2'b00, 1'b0, 12'h805};
    vecs[4] = '{8'hFF, 8'h00, 2'b10, 1'b1, 12'h00E};
    vecs[5] = '{8'h10, 8'h01, 2'b11, 1'b0, 12'h0E8};
    vecs[6] = '{8'h80, 8'h01, 2'b01, 1'b0, 12'h7F9};
    vecs[7] = '{8'h12, 8'h34, 2'b10, 1'b0, 12'h460};
    vecs[8] = '{8'h34, 8'h12, 2'b11, 1'b1, 12'h22C};
    vecs[9] = '{8'h01, 8'h01, 2'b00, 1'b1, 12'h020};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = 2'b00;
    carryIn = 1'b0; abort = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", 32'({carry, digitCarry, zero, overflow}), 32'd0);
    check("reset state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed vectors
    foreach (vecs[i]) begin
      issue(vecs[i].va, vecs[i].vb, vecs[i].vm, vecs[i].vc, vecs[i].ve, 1'b1, c1);
      in_valid = 1'b0;
      wait_idle();
    end

    // backpressure: hold out_ready low for 5 cycles in DONE
    out_ready = 1'b0;
    issue(8'h0F, 8'h01, 2'b00, 1'b0, 12'h104, 1'b1, c1);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) timeout_fail("hold out_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold result", 32'(result), 32'h10);
      check("hold flags", 32'({carry, digitCarry, zero, overflow}), 32'b0100);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release idle in_ready", 32'(in_ready), 32'd1);
    check("release idle state", 32'(state_dbg), 32'd0);
    rel_cyc = cyc;
    issue(8'h01, 8'h01, 2'b00, 1'b1, 12'h020, 1'b1, c1);
    in_valid = 1'b0;
    check("accept after release", 32'(c1), 32'(rel_cyc + 1));
    wait_idle();

    // abort after slice 0
    issue(8'hF0, 8'h0F, 2'b00, 1'b0, '0, 1'b0, c1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort state", 32'(state_dbg), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result kept", 32'(result), 32'h02);
    repeat (4) @(posedge clk);
    #1;

    // back-to-back with in_valid held high: in_ready low for N+1 cycles between accepts
    issue(8'h05, 8'h05, 2'b01, 1'b0, 12'h00E, 1'b1, c1);
    issue(8'h7F, 8'h01, 2'b00, 1'b0, 12'h805, 1'b1, c2);
    in_valid = 1'b0;
    check("busy cycles between accepts", 32'(c2 - c1 - 1), 32'(N + 1));
    wait_idle();

    // asynchronous reset in the middle of CALC
    issue(8'h22, 8'h11, 2'b00, 1'b0, '0, 1'b0, c1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst in_ready", 32'(in_ready), 32'd1);
    check("async rst out_valid", 32'(out_valid), 32'd0);
    check("async rst result", 32'(result), 32'd0);
    check("async rst flags", 32'({carry, digitCarry, zero, overflow}), 32'd0);
    check("async rst state", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel_cyc = cyc;
    issue(8'h01, 8'h01, 2'b00, 1'b0, 12'h020, 1'b1, c1);
    in_valid = 1'b0;
    check("accept after reset", 32'(c1), 32'(rel_cyc + 1));
    wait_idle();

    repeat (3) @(posedge clk);
    #1;
    check("results outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
